pic: RTL and testbench
======================

# pic

Programmable interrupt controller that sequences hardware interrupt requests into the CPU's `irq_signal`/`irq_id` pair. It arbitrates eight edge-triggered request lines by fixed priority and tracks in-service state. It is programmed through I/O ports 0x20/0x21 with a reduced 8259A command set. It sits between peripheral request sources (timer, keyboard) and the CPU, and shares the CPU port bus with `ctl_port`.

## Interface
Parameters:
- `BASE_PORT`, 16'h0020: command port; the data/mask port is `BASE_PORT+1`.
- `RESET_VECTOR`, 8'h08: vector base after reset; the low 3 bits are ignored.

Ports:
- `clock`  in  1  CPU clock. One clock; all logic runs on its rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `irq_in`  in  8  request lines, synchronous to `clock`. Bit 0 has the highest priority.
- `port_address`  in  16  CPU I/O address.
- `port_write`  in  1  single-cycle write strobe.
- `port_read`  in  1  read strobe.
- `port_out`  in  8  write data from the CPU.
- `port_in`  out  8  read data to the CPU. Combinational; 8'h00 when the address does not match.
- `irq_signal`  out  1  interrupt request to the CPU. Registered.
- `irq_id`  out  8  vector number, `{vbase[7:3], n[2:0]}`. Registered.
- `irq_ack`  in  1  single-cycle pulse from the CPU when it accepts the pending vector.

## Operation
Reset values:
- IMR = 8'hFF; IRR = ISR = 0; `vbase` = RESET_VECTOR.
- Read-select = IRR; `irq_in` history = 0.
- State READY_IDLE; `irq_signal` = 0; `irq_id` = 8'h00.

Edge capture:
- `prev <= irq_in` every cycle.
- `irq_in[n] & ~prev[n]` sets IRR[n].
- A level held high does not retrigger.

Arbitration (READY states only):
- Candidate n is the lowest-numbered set bit of `IRR & ~IMR`.
- The candidate is valid only if no ISR bit ≤ n is set. This gives fully nested priority.

Main FSM:
- READY_IDLE: on a valid candidate, latch n, set `irq_signal`=1 and `irq_id`={vbase[7:3],n}, then go to PEND.
- PEND: outputs are held stable. A newly arriving higher-priority request does not replace the latched n.
  - On `irq_ack`: IRR[n]←0, ISR[n]←1, `irq_signal`←0, go to READY_IDLE.
  - If IMR[n] becomes 1 before ack: `irq_signal`←0, go to READY_IDLE. IRR[n] is kept.
- INIT_ICW2: the next data-port write sets `vbase`←`port_out`[7:3]. Then go to INIT_ICW3 if ICW1 bit1=0, else INIT_ICW4 if ICW1 bit0=1, else READY_IDLE.
- INIT_ICW3: the next data-port write is discarded. Then go to INIT_ICW4 if IC4, else READY_IDLE.
- INIT_ICW4: the next data-port write is discarded. Go to READY_IDLE.

Command port write (any state):
- Bit4=1 (ICW1): IMR←0, ISR←0, IRR←0, read-select←IRR, `irq_signal`←0, go to INIT_ICW2.
- 8'h20: non-specific EOI, clears the lowest-numbered set ISR bit.
- 8'h60|k: specific EOI, clears ISR[k].
- 8'h0A / 8'h0B: read-select = IRR / ISR.
- Other values are ignored.

Data port write in READY states: IMR←`port_out`.

Reads:
- Command port returns IRR or ISR per read-select.
- Data port returns IMR.
- Reads have no side effects.

## Timing
Request latency:
- `irq_in[n]` first sampled high at edge t: IRR[n] is set at t.
- `irq_signal` goes high at t+1 if the candidate is valid.

Ack:
- `irq_ack` at edge t: ISR/IRR update and `irq_signal` is low after t.
- The next request can assert at t+1 at the earliest.

Simultaneous events in one cycle:
- New edge on n and ack of n: ISR[n]←1 and IRR[n] stays 1 (new request retained).
- EOI and ack: both apply. The EOI is computed on the pre-ack ISR.
- ICW1 and ack: ICW1 wins and ISR ends at 0.
- IMR write masking the latched n and ack: ack wins.

Other boundaries:
- All ISR bits set: no request is issued. EOI with ISR=0 is a no-op.
- `reset` overrides everything, including mid-PEND or mid-INIT; every register returns to its reset value the same edge.

## Test plan
- After reset, pulse `irq_in[1]`: nothing is raised (IMR=FF). Write 21h←FD: `irq_signal`=1 next cycle with `irq_id`=8'h09. Pulse `irq_ack`: reading 20h after writing 0Bh gives 8'h02.
- Init 20h←11h, 21h←70h, 21h←04h, 21h←01h, 21h←00h, then raise `irq_in[0]`: `irq_id`=8'h70. IMR reads 00h during init.
- With ISR[3] set, raise `irq_in[5]` and `irq_in[2]` together: vector for 2 is issued. After its ack, 5 is held until EOI 20h←20h twice.
- Raise `irq_in[4]` and ack it in the same cycle as a new edge on line 4: ISR=10h and IRR=10h. Write 20h←64h: ISR=00h and a new request is issued.
- While in PEND on line 6, write 21h←40h: `irq_signal` drops the next cycle and IRR bit 6 stays set. Unmask: the request reasserts with `irq_id`=vbase|6.
- Assert `reset` mid-PEND and mid-INIT_ICW3: all outputs and registers return to their reset values on that edge.

Source files
------------

// File: rtl/pic.sv
// pic: 8-line edge-triggered priority interrupt controller with a reduced 8259A command set
// Ports: clock/reset (sync, active-high); irq_in request lines (bit 0 highest);
//        port_address/port_write/port_read/port_out/port_in CPU I/O bus at BASE_PORT and BASE_PORT+1;
//        irq_signal/irq_id registered request and vector to the CPU; irq_ack accepts the pending vector.
module pic #(
    parameter logic [15:0] BASE_PORT    = 16'h0020,
    parameter logic [7:0]  RESET_VECTOR = 8'h08
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  irq_in,
    input  logic [15:0] port_address,
    input  logic        port_write,
    input  logic        port_read,
    input  logic [7:0]  port_out,
    output logic [7:0]  port_in,
    output logic        irq_signal,
    output logic [7:0]  irq_id,
    input  logic        irq_ack
);
    typedef enum logic [2:0] {READY_IDLE, PEND, INIT_ICW2, INIT_ICW3, INIT_ICW4} state_t;
    state_t state, state_d;
    logic [7:0] imr, irr, isr, prev, imr_d, irr_d, isr_d, irq_id_d;
    logic [7:0] req, cand_oh, eoi_clr, ack_oh;
    logic [4:0] vbase, vbase_d;
    logic [2:0] cur_n, cur_n_d, cand;
    logic rsel, rsel_d, sngl, sngl_d, ic4, ic4_d;
    logic cmd_wr, data_wr, icw1, ready, cand_ok, ack;

    assign cmd_wr  = port_write && port_address == BASE_PORT;
    assign data_wr = port_write && port_address == BASE_PORT + 16'd1;
    assign icw1    = cmd_wr && port_out[4];
    assign ready   = state == READY_IDLE || state == PEND;
    assign ack     = state == PEND && irq_ack;
    assign ack_oh  = ack ? 8'd1 << cur_n : 8'd0;
    assign req     = irr & ~imr;
    assign cand_oh = req & (~req + 8'd1);
    // Fully nested: any in-service line at or above the candidate's priority blocks it.
    assign cand_ok = |req && (isr & (cand_oh | (cand_oh - 8'd1))) == 8'd0;

    always_comb begin
        cand = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (req[i]) cand = i[2:0];
    end

    // EOI is taken against the pre-ack ISR so a same-cycle ack survives it.
    assign eoi_clr = !cmd_wr || icw1 ? 8'd0 :
                     port_out == 8'h20 ? isr & (~isr + 8'd1) :
                     port_out[7:3] == 5'b01100 ? 8'd1 << port_out[2:0] : 8'd0;

    always_ff @(posedge clock) begin
        if (reset) state <= READY_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (icw1) state_d = INIT_ICW2;
        else case (state)
            READY_IDLE: if (cand_ok) state_d = PEND;
            PEND:       if (irq_ack || imr_d[cur_n]) state_d = READY_IDLE;
            INIT_ICW2:  if (data_wr) state_d = !sngl ? INIT_ICW3 : ic4 ? INIT_ICW4 : READY_IDLE;
            INIT_ICW3:  if (data_wr) state_d = ic4 ? INIT_ICW4 : READY_IDLE;
            INIT_ICW4:  if (data_wr) state_d = READY_IDLE;
            default:    state_d = READY_IDLE;
        endcase
    end

    always_comb begin
        irq_signal = state == PEND;
        port_in    = !port_read ? 8'h00 :
                     port_address == BASE_PORT ? (rsel ? isr : irr) :
                     port_address == BASE_PORT + 16'd1 ? imr : 8'h00;
    end

    always_comb begin
        imr_d    = icw1 ? 8'h00 : data_wr && ready ? port_out : imr;
        irr_d    = icw1 ? 8'h00 : (irr & ~ack_oh) | (irq_in & ~prev);
        isr_d    = icw1 ? 8'h00 : (isr & ~eoi_clr) | ack_oh;
        rsel_d   = icw1 ? 1'b0 : cmd_wr && port_out == 8'h0B ? 1'b1 : cmd_wr && port_out == 8'h0A ? 1'b0 : rsel;
        vbase_d  = !icw1 && state == INIT_ICW2 && data_wr ? port_out[7:3] : vbase;
        sngl_d   = icw1 ? port_out[1] : sngl;
        ic4_d    = icw1 ? port_out[0] : ic4;
        cur_n_d  = !icw1 && state == READY_IDLE && cand_ok ? cand : cur_n;
        irq_id_d = !icw1 && state == READY_IDLE && cand_ok ? {vbase, cand} : irq_id;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            imr    <= 8'hFF;
            irr    <= 8'h00;
            isr    <= 8'h00;
            prev   <= 8'h00;
            rsel   <= 1'b0;
            vbase  <= RESET_VECTOR[7:3];
            sngl   <= 1'b0;
            ic4    <= 1'b0;
            cur_n  <= 3'd0;
            irq_id <= 8'h00;
        end else begin
            imr    <= imr_d;
            irr    <= irr_d;
            isr    <= isr_d;
            prev   <= irq_in;
            rsel   <= rsel_d;
            vbase  <= vbase_d;
            sngl   <= sngl_d;
            ic4    <= ic4_d;
            cur_n  <= cur_n_d;
            irq_id <= irq_id_d;
        end
    end
endmodule

// File: tb/tb_pic.sv
// tb_pic: directed self-checking bench for the pic interrupt controller
module tb_pic;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  irq_in = 8'h00;
    logic [15:0] port_address = 16'h0000;
    logic        port_write = 1'b0;
    logic        port_read = 1'b0;
    logic [7:0]  port_out = 8'h00;
    logic [7:0]  port_in;
    logic        irq_signal;
    logic [7:0]  irq_id;
    logic        irq_ack = 1'b0;
    int checks = 0;
    int passed = 0;
    logic [7:0] rv;

    pic dut (
        .clock(clock), .reset(reset), .irq_in(irq_in), .port_address(port_address),
        .port_write(port_write), .port_read(port_read), .port_out(port_out),
        .port_in(port_in), .irq_signal(irq_signal), .irq_id(irq_id), .irq_ack(irq_ack)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        port_address = a;
        port_out = d;
        port_write = 1'b1;
        step();
        port_write = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        port_address = a;
        port_read = 1'b1;
        #1;
        d = port_in;
        port_read = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] lines);
        irq_in = lines;
        step();
        irq_in = 8'h00;
    endtask

    task automatic do_ack();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask

    task automatic rd_isr(input string tag, input logic [7:0] exp);
        wr(16'h20, 8'h0B);
        rd(16'h20, rv);
        check(tag, rv, exp);
        wr(16'h20, 8'h0A);
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        check("rst_sig", {7'd0, irq_signal}, 8'h00);
        check("rst_id", irq_id, 8'h00);
        rd(16'h21, rv); check("rst_imr", rv, 8'hFF);
        rd(16'h20, rv); check("rst_irr", rv, 8'h00);
        rd(16'h22, rv); check("bad_addr", rv, 8'h00);
        // masked request
        pulse(8'h02);
        step();
        check("masked_sig", {7'd0, irq_signal}, 8'h00);
        rd(16'h20, rv); check("masked_irr", rv, 8'h02);
        wr(16'h21, 8'hFD);
        check("unmask_edge", {7'd0, irq_signal}, 8'h00);
        step();
        check("unmask_sig", {7'd0, irq_signal}, 8'h01);
        check("unmask_id", irq_id, 8'h09);
        do_ack();
        check("ack_sig", {7'd0, irq_signal}, 8'h00);
        rd_isr("ack_isr", 8'h02);
        rd(16'h20, rv); check("ack_irr", rv, 8'h00);
        wr(16'h20, 8'h20);
        rd_isr("eoi_isr", 8'h00);
        // init sequence
        wr(16'h20, 8'h11);
        rd(16'h21, rv); check("init_imr0", rv, 8'h00);
        wr(16'h21, 8'h70);
        wr(16'h21, 8'h04);
        rd(16'h21, rv); check("init_imr1", rv, 8'h00);
        wr(16'h21, 8'h01);
        wr(16'h21, 8'h00);
        rd(16'h21, rv); check("init_imr2", rv, 8'h00);
        irq_in = 8'h01;
        step();
        step();
        check("init_sig", {7'd0, irq_signal}, 8'h01);
        check("init_id", irq_id, 8'h70);
        do_ack();
        rd_isr("init_isr", 8'h01);
        wr(16'h20, 8'h20);
        step();
        step();
        check("level_noretrig", {7'd0, irq_signal}, 8'h00);
        irq_in = 8'h00;
        // nested priority
        pulse(8'h08);
        step();
        check("n3_id", irq_id, 8'h73);
        do_ack();
        pulse(8'h24);
        step();
        check("n2_sig", {7'd0, irq_signal}, 8'h01);
        check("n2_id", irq_id, 8'h72);
        do_ack();
        step();
        check("n5_blocked", {7'd0, irq_signal}, 8'h00);
        rd(16'h20, rv); check("n5_irr", rv, 8'h20);
        wr(16'h20, 8'h20);
        step();
        check("n5_blocked2", {7'd0, irq_signal}, 8'h00);
        rd_isr("n_isr", 8'h08);
        wr(16'h20, 8'h20);
        step();
        check("n5_sig", {7'd0, irq_signal}, 8'h01);
        check("n5_id", irq_id, 8'h75);
        do_ack();
        wr(16'h20, 8'h20);
        // ack coincident with new edge on same line
        pulse(8'h10);
        step();
        check("l4_id", irq_id, 8'h74);
        irq_in = 8'h10;
        irq_ack = 1'b1;
        step();
        irq_in = 8'h00;
        irq_ack = 1'b0;
        check("l4_ack_sig", {7'd0, irq_signal}, 8'h00);
        rd_isr("l4_isr", 8'h10);
        rd(16'h20, rv); check("l4_irr", rv, 8'h10);
        wr(16'h20, 8'h64);
        check("l4_eoi_edge", {7'd0, irq_signal}, 8'h00);
        step();
        check("l4_re_sig", {7'd0, irq_signal}, 8'h01);
        check("l4_re_id", irq_id, 8'h74);
        rd_isr("l4_seoi_isr", 8'h00);
        do_ack();
        wr(16'h20, 8'h20);
        // mask while pending
        pulse(8'h40);
        step();
        check("l6_id", irq_id, 8'h76);
        wr(16'h21, 8'h40);
        check("l6_drop", {7'd0, irq_signal}, 8'h00);
        rd(16'h20, rv); check("l6_irr_kept", rv, 8'h40);
        wr(16'h21, 8'h00);
        step();
        check("l6_re_sig", {7'd0, irq_signal}, 8'h01);
        check("l6_re_id", irq_id, 8'h76);
        irq_ack = 1'b1;
        wr(16'h21, 8'h40);
        irq_ack = 1'b0;
        check("mask_ack_sig", {7'd0, irq_signal}, 8'h00);
        rd_isr("mask_ack_isr", 8'h40);
        rd(16'h20, rv); check("mask_ack_irr", rv, 8'h00);
        wr(16'h21, 8'h00);
        wr(16'h20, 8'h20);
        // reset mid-PEND
        pulse(8'h02);
        step();
        check("pre_rst_sig", {7'd0, irq_signal}, 8'h01);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("prst_sig", {7'd0, irq_signal}, 8'h00);
        check("prst_id", irq_id, 8'h00);
        rd(16'h21, rv); check("prst_imr", rv, 8'hFF);
        rd(16'h20, rv); check("prst_irr", rv, 8'h00);
        // reset mid-INIT_ICW3
        wr(16'h20, 8'h11);
        wr(16'h21, 8'h70);
        reset = 1'b1;
        step();
        reset = 1'b0;
        rd(16'h21, rv); check("irst_imr", rv, 8'hFF);
        wr(16'h21, 8'hFE);
        rd(16'h21, rv); check("irst_ready", rv, 8'hFE);
        pulse(8'h01);
        step();
        check("irst_sig", {7'd0, irq_signal}, 8'h01);
        check("irst_vbase", irq_id, 8'h08);
        do_ack();
        rd_isr("irst_isr", 8'h01);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
